mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage that sits directly downstream of the execute stage. It takes the ALU-computed effective address and store data for MIPS loads and stores, runs one data-bus transaction per access with a ready handshake and timeout, and returns sign- or zero-extended load data. While an access is in flight it holds the pipeline with a `stall` request, using the same contract as the execute-stage multiplier stall.

## Interface
Parameters:
- `TIMEOUT`, default 16: number of BUSY cycles without `mem_ready` before the stage aborts with `bus_err` (legal range 1..255).

Ports:
- `sys_clk` input 1: system clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `is_load_store` input 1: the current instruction is a load or store.
- `opcode` input 6: instruction opcode; selects size, sign, direction.
- `addr` input 32: effective address (execute `result`).
- `store_data` input 32: rt value (execute `reg2`).
- `load_data` output 32: extended load result; valid in the DONE cycle of a load, 0 otherwise.
- `stall` output 1: pipeline hold request.
- `addr_err` output 1: misaligned access (combinational).
- `bus_err` output 1: timeout abort; high only in the DONE cycle.
- `mem_req` output 1: bus request.
- `mem_we` output 1: 1 = write.
- `mem_addr` output 32: word address; bits [1:0] are always 0.
- `mem_be` output 4: byte enables; bit i = byte lane i, little-endian.
- `mem_wdata` output 32: lane-replicated store data.
- `mem_rdata` input 32: read data; valid when `mem_ready`.
- `mem_ready` input 1: transaction completes this cycle.

## Operation
- Opcodes:
  - Loads: lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101.
  - Stores: sb 101000, sh 101001, sw 101011.
  - Any other opcode with `is_load_store` set is treated as lw/sw by `opcode[3]`.
- Alignment:
  - Halfword accesses require `addr[0]==0`; word accesses require `addr[1:0]==0`.
  - On misalignment: `addr_err` = 1, `stall` = 0, no bus transaction, state stays IDLE.
- FSM:
  - IDLE: on an aligned access, latch `mem_addr`, `mem_we`, `mem_be`, `mem_wdata`, and the load format (size, sign, byte offset); clear the timeout counter; go to BUSY.
  - BUSY: `mem_req` = 1 and the counter increments.
    - On `mem_ready`: capture `mem_rdata` and go to DONE.
    - Else, when the counter reaches `TIMEOUT`: go to DONE with `bus_err` set.
  - DONE: one cycle with `stall` = 0 so the pipeline advances; always returns to IDLE.
- `stall` = `is_load_store` && aligned && (state != DONE).
- Byte enables:
  - sb: 1 << `addr[1:0]`.
  - sh: 0011 or 1100.
  - sw: 1111.
  - Loads use the same enables with `mem_we` = 0.
- Write data: sb replicates byte [7:0] to all four lanes; sh replicates halfword [15:0] to both halves; sw passes through.
- Load extraction: select the addressed lane of the captured word; lb/lh sign-extend, lbu/lhu zero-extend.
- Timeout or store: `load_data` = 0 in DONE.
- `mem_ready` outside BUSY is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0. Reset asserted mid-BUSY drops `mem_req` immediately with no completion.
- Zero-wait access: cycle 0 IDLE (stall = 1), cycle 1 BUSY with `mem_req` and `mem_ready` (stall = 1), cycle 2 DONE (stall = 0, data valid). Each wait state adds one cycle.
- Back-to-back accesses: DONE → IDLE → BUSY. Minimum 3 cycles per access.
- `mem_addr`, `mem_be`, `mem_we`, and `mem_wdata` are stable for the whole time `mem_req` is high.
- Timeout: DONE is entered on the edge after the `TIMEOUT`-th BUSY cycle without ready. If ready arrives in that same cycle, ready wins and `bus_err` = 0.

## Structure
- Shared package `mem_pkg` holds:
  - Opcode localparams.
  - FSM state enum (IDLE, BUSY, DONE).
  - Size encoding (BYTE, HALF, WORD).
- One combinational sub-module, `load_extend`: inputs are the word, offset, size, and sign; output is 32 bits. It is instantiated once.

## Test plan
- sw addr 0x100, data 0xDEADBEEF, ready on the first BUSY cycle → `mem_be` 1111, `mem_we` 1; stall pattern 1,1,0.
- lb addr 0x203, rdata 0x80FFFFFF → `load_data` 0xFFFFFF80; lbu same → 0x00000080.
- sh addr 0x12, data 0x0000ABCD → `mem_be` 1100, `mem_wdata` 0xABCDABCD. lhu addr 0x12, rdata 0x1234ABCD → 0x00001234.
- lw addr 0x102 → `addr_err` 1, `stall` 0, `mem_req` never asserts.
- lw with `mem_ready` held low, `TIMEOUT`=4 → `mem_req` high for 4 cycles, then DONE with `bus_err` 1 and `load_data` 0.
- Reset pulse during BUSY with 3 wait states → `mem_req` 0 immediately; after release, a new lw completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory-access stage.
//   - MIPS load/store opcode constants
//   - FSM state encoding (IDLE, BUSY, DONE)
//   - access size encoding (BYTE, HALF, WORD)
//   - opcode decode helpers for size and signedness
package mem_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {BYTE, HALF, WORD} size_t;

  // Unrecognised load/store opcodes fall back to a full word access.
  function automatic size_t op_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = BYTE;
      OP_LH, OP_LHU, OP_SH: op_size = HALF;
      default:              op_size = WORD;
    endcase
  endfunction

  function automatic logic op_signed(input logic [5:0] op);
    op_signed = (op == OP_LB) || (op == OP_LH);
  endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/halfword lane of a little-endian
// bus word and sign- or zero-extends it to 32 bits. Purely combinational.
//   word      : captured 32-bit read data
//   offset    : byte offset within the word (addr[1:0])
//   size      : BYTE / HALF / WORD
//   is_signed : 1 = sign-extend, 0 = zero-extend
//   data      : extended result
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  size_t       size,
  input  logic        is_signed,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = 8'd0;
    lane_h = 16'd0;
    data   = word;
    case (offset)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = offset[1] ? word[31:16] : word[15:0];
    case (size)
      BYTE:    data = {{24{is_signed & lane_b[7]}}, lane_b};
      HALF:    data = {{16{is_signed & lane_h[15]}}, lane_h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory-access stage downstream of execute. Runs one data-bus
// transaction per MIPS load/store with a ready handshake and timeout, and
// holds the pipeline with stall while the access is in flight.
//   sys_clk, rst_n      : clock, asynchronous active-low reset
//   is_load_store       : current instruction is a load or store
//   opcode, addr        : opcode and effective address from execute
//   store_data          : rt value for stores
//   load_data           : extended load result (DONE cycle of a load only)
//   stall               : pipeline hold request
//   addr_err            : misaligned access (combinational)
//   bus_err             : timeout abort, DONE cycle only
//   mem_req/we/addr/be/wdata : bus request side, stable while mem_req
//   mem_rdata, mem_ready     : bus response side
module mem_access
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        is_load_store,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        addr_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_t      state;
  logic [7:0]  cnt;
  size_t       size_q;
  logic        sign_q;
  logic [1:0]  off_q;

  size_t       acc_size;
  logic        misalign;
  logic        access_ok;
  logic [3:0]  acc_be;
  logic [31:0] acc_wdata;
  logic [31:0] ext_data;

  // Decode of the instruction presented by execute.
  always_comb begin
    acc_size  = op_size(opcode);
    misalign  = 1'b0;
    acc_be    = 4'b1111;
    acc_wdata = store_data;
    case (acc_size)
      BYTE: begin
        acc_be    = 4'b0001 << addr[1:0];
        acc_wdata = {4{store_data[7:0]}};
      end
      HALF: begin
        misalign  = addr[0];
        acc_be    = addr[1] ? 4'b1100 : 4'b0011;
        acc_wdata = {2{store_data[15:0]}};
      end
      default: misalign = |addr[1:0];
    endcase
  end

  assign addr_err  = is_load_store & misalign;
  assign access_ok = is_load_store & ~misalign;
  // DONE releases the pipeline for exactly one cycle.
  assign stall     = access_ok & (state != DONE);
  assign mem_req   = (state == BUSY);

  load_extend u_load_extend (
    .word      (mem_rdata),
    .offset    (off_q),
    .size      (size_q),
    .is_signed (sign_q),
    .data      (ext_data)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      size_q    <= BYTE;
      sign_q    <= 1'b0;
      off_q     <= 2'd0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      load_data <= 32'd0;
      bus_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          load_data <= 32'd0;
          bus_err   <= 1'b0;
          if (access_ok) begin
            mem_addr  <= {addr[31:2], 2'b00};
            mem_we    <= opcode[3];
            mem_be    <= acc_be;
            mem_wdata <= acc_wdata;
            size_q    <= acc_size;
            sign_q    <= op_signed(opcode);
            off_q     <= addr[1:0];
            cnt       <= 8'd0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt + 8'd1;
          // Ready in the final allowed cycle still completes normally.
          if (mem_ready) begin
            load_data <= mem_we ? 32'd0 : ext_data;
            state     <= DONE;
          end else if (cnt + 8'd1 == TO_LIMIT) begin
            bus_err <= 1'b1;
            state   <= DONE;
          end
        end
        default: begin
          load_data <= 32'd0;
          bus_err   <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  import mem_pkg::*;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        is_load_store;
  logic [5:0]  opcode;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        stall;
  logic        addr_err;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] ld;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  always #5 sys_clk = ~sys_clk;

  mem_access #(.TIMEOUT(4)) dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .is_load_store (is_load_store),
    .opcode        (opcode),
    .addr          (addr),
    .store_data    (store_data),
    .load_data     (load_data),
    .stall         (stall),
    .addr_err      (addr_err),
    .bus_err       (bus_err),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full access: drive in IDLE, answer the bus after 'waits' wait
  // states (negative = never answer), then score the DONE cycle.
  task automatic run_access(input logic [5:0] opc, input logic [31:0] a,
                            input logic [31:0] sd, input logic [31:0] rd,
                            input int waits, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_ld,
                            input logic exp_err);
    exp_t e;
    int   n;
    int   exp_cycles;
    e.ld  = exp_ld;
    e.err = exp_err;
    sb_q.push_back(e);
    exp_cycles = (waits < 0 || waits >= 4) ? 4 : waits + 1;

    @(negedge sys_clk);
    is_load_store = 1'b1;
    opcode        = opc;
    addr          = a;
    store_data    = sd;
    mem_rdata     = rd;
    mem_ready     = 1'b0;
    #1;
    check("idle_stall", 32'(stall), 32'd1);
    check("idle_req", 32'(mem_req), 32'd0);
    check("aligned_addr_err", 32'(addr_err), 32'd0);

    n = 0;
    @(negedge sys_clk);
    while (mem_req === 1'b1 && n < 40) begin
      check("busy_be", 32'(mem_be), 32'(exp_be));
      check("busy_we", 32'(mem_we), 32'(opc[3]));
      check("busy_addr", mem_addr, {a[31:2], 2'b00});
      if (opc[3]) check("busy_wdata", mem_wdata, exp_wdata);
      check("busy_stall", 32'(stall), 32'd1);
      mem_ready = (n == waits);
      @(negedge sys_clk);
      n++;
    end
    mem_ready = 1'b0;
    check("req_cycles", 32'(n), 32'(exp_cycles));
    check("done_stall", 32'(stall), 32'd0);
    e = sb_q.pop_front();
    check("done_load_data", load_data, e.ld);
    check("done_bus_err", 32'(bus_err), 32'(e.err));
    is_load_store = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n         = 1'b0;
    is_load_store = 1'b0;
    opcode        = 6'd0;
    addr          = 32'd0;
    store_data    = 32'd0;
    mem_rdata     = 32'd0;
    mem_ready     = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    rst_n = 1'b1;

    run_access(OP_SW,  32'h100, 32'hDEADBEEF, 32'h0,        0, 4'b1111, 32'hDEADBEEF, 32'h0,        1'b0);
    run_access(OP_LB,  32'h203, 32'h0,        32'h80FFFFFF, 0, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0);
    @(negedge sys_clk);
    check("after_done_load_data", load_data, 32'd0);
    run_access(OP_LBU, 32'h203, 32'h0,        32'h80FFFFFF, 1, 4'b1000, 32'h0,        32'h00000080, 1'b0);
    run_access(OP_LB,  32'h201, 32'h0,        32'h12347F56, 0, 4'b0010, 32'h0,        32'h0000007F, 1'b0);
    run_access(OP_SH,  32'h012, 32'h0000ABCD, 32'h0,        0, 4'b1100, 32'hABCDABCD, 32'h0,        1'b0);
    run_access(OP_LHU, 32'h012, 32'h0,        32'h1234ABCD, 0, 4'b1100, 32'h0,        32'h00001234, 1'b0);
    run_access(OP_LH,  32'h010, 32'h0,        32'h12348001, 2, 4'b0011, 32'h0,        32'hFFFF8001, 1'b0);
    run_access(OP_SB,  32'h201, 32'h1234565A, 32'h0,        1, 4'b0010, 32'h5A5A5A5A, 32'h0,        1'b0);
    run_access(OP_LW,  32'h400, 32'h0,        32'hCAFEF00D, 3, 4'b1111, 32'h0,        32'hCAFEF00D, 1'b0);
    run_access(OP_LW,  32'h404, 32'h0,        32'h55555555, -1, 4'b1111, 32'h0,       32'h0,        1'b1);

    // Misaligned word and halfword: flagged, no stall, no bus activity.
    @(negedge sys_clk);
    is_load_store = 1'b1;
    opcode        = OP_LW;
    addr          = 32'h102;
    #1;
    check("mis_lw_addr_err", 32'(addr_err), 32'd1);
    check("mis_lw_stall", 32'(stall), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      check("mis_lw_req", 32'(mem_req), 32'd0);
    end
    opcode = OP_SH;
    addr   = 32'h13;
    #1;
    check("mis_sh_addr_err", 32'(addr_err), 32'd1);
    check("mis_sh_stall", 32'(stall), 32'd0);
    @(negedge sys_clk);
    check("mis_sh_req", 32'(mem_req), 32'd0);
    is_load_store = 1'b0;

    // Reset in the middle of a waiting access.
    @(negedge sys_clk);
    is_load_store = 1'b1;
    opcode        = OP_LW;
    addr          = 32'h300;
    mem_ready     = 1'b0;
    @(negedge sys_clk);
    check("rstmid_req_before", 32'(mem_req), 32'd1);
    @(negedge sys_clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_req", 32'(mem_req), 32'd0);
    check("rstmid_bus_err", 32'(bus_err), 32'd0);
    check("rstmid_load_data", load_data, 32'd0);
    is_load_store = 1'b0;
    @(negedge sys_clk);
    rst_n = 1'b1;
    run_access(OP_LW,  32'h300, 32'h0,        32'h13579BDF, 1, 4'b1111, 32'h0,        32'h13579BDF, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
